// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_det_pkg;

  localparam int          SEQ_DET_DEF_W   = 4;
  localparam logic [3:0]  SEQ_DET_DEF_PAT = 4'b1011;
  localparam int          SEQ_DET_DEF_CNT = 8;

  // Bits needed to hold a match length in 0..w.
  function automatic int seq_state_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Length of the longest suffix of (first k pattern bits, then b) that is also
  // a prefix of the pattern, capped at w. Pattern MSB (bit w-1) is received first.
  // Only ever evaluated on constants, so it folds into a fixed transition table.
  function automatic int seq_next_state(input int k, input logic b, input int w,
                                        input logic [15:0] pat);
    logic [16:0] s;
    int          len_s;
    int          best;
    bit          ok;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < k) s[i] = pat[w-1-i];
    end
    s[k]  = b;
    len_s = k + 1;
    best  = 0;
    for (int len = 1; len <= 16; len++) begin
      if (len <= w && len <= len_s) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (i < len) begin
            if (s[len_s-len+i] != pat[w-1-i]) ok = 1'b0;
          end
        end
        if (ok) best = len;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sequence_detector_moore.sv
// Moore detector for a serial bit pattern with overlapping matches; optional
// saturating match counter when SEQ_DET_COUNT_EN is defined.
// Latency: detector_out high the cycle after the edge that samples the last bit.
// Backpressure: none; every rising edge consumes one bit.
module sequence_detector_moore
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W = SEQ_DET_DEF_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(SEQ_DET_DEF_PAT),
  parameter int                   CNT_W     = SEQ_DET_DEF_CNT
) (
  input  logic clock,
  input  logic reset,
  input  logic sequence_in,
  output logic detector_out
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] detect_count
`endif
);

  localparam int SW = seq_state_w(PATTERN_W);
  localparam int NS = 1 << SW;
  localparam logic [SW-1:0] FULL = SW'(PATTERN_W);

  if (PATTERN_W < 2 || PATTERN_W > 16 || CNT_W < 1) begin : g_bad_params
    $error("sequence_detector_moore: PATTERN_W must be 2..16 and CNT_W >= 1");
  end

  // State = number of pattern bits currently matched.
  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  // Constant transition tables, one per input bit value. Encodings above
  // PATTERN_W are unreachable and fall back to 0.
  logic [NS-1:0][SW-1:0] nxt_on0;
  logic [NS-1:0][SW-1:0] nxt_on1;

  for (genvar g = 0; g < NS; g++) begin : g_tbl
    if (g <= PATTERN_W) begin : g_live
      assign nxt_on0[g] = SW'(seq_next_state(g, 1'b0, PATTERN_W, 16'(PATTERN)));
      assign nxt_on1[g] = SW'(seq_next_state(g, 1'b1, PATTERN_W, 16'(PATTERN)));
    end else begin : g_dead
      assign nxt_on0[g] = '0;
      assign nxt_on1[g] = '0;
    end
  end

  // Next-state lookup from the current match length and the incoming bit.
  always_comb begin
    state_d = '0;
    if (sequence_in) state_d = nxt_on1[state_q];
    else             state_d = nxt_on0[state_q];
  end

  // State register; reset drops any partial match.
  always_ff @(posedge clock) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  // Moore output decoded from the register only.
  assign detector_out = (state_q == FULL);

`ifdef SEQ_DET_COUNT_EN
  // Count edges that enter the full-match state; hold at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      detect_count <= '0;
    end else if (state_d == FULL && detect_count != '1) begin
      detect_count <= detect_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sequence_detector_moore.sv
// Bench for sequence_detector_moore: directed sequences plus random bits,
// checked every cycle against a sliding-window model of the received stream.
// Backpressure: n/a.
module tb_sequence_detector_moore;

  localparam int         W   = 4;
  localparam logic [3:0] PAT = 4'b1011;
  localparam int         CW  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sequence_in = 1'b0;
  logic detector_out;
`ifdef SEQ_DET_COUNT_EN
  logic [CW-1:0] detect_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sequence_detector_moore #(
    .PATTERN_W(W),
    .PATTERN  (PAT),
    .CNT_W    (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sequence_in (sequence_in),
    .detector_out(detector_out)
`ifdef SEQ_DET_COUNT_EN
    ,
    .detect_count(detect_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expd);
    checks++;
    if (act !== expd) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expd, $time);
    end
  endtask

  // Model: the stream since reset, kept as a window of recent bits. A match is
  // simply "at least W bits seen and the last W bits equal the pattern".
  logic [31:0] hist;
  int          nbits;
  bit          exp_out;
  int          exp_cnt;
  bit          armed = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      hist    = '0;
      nbits   = 0;
      exp_out = 1'b0;
      exp_cnt = 0;
      armed   = 1'b1;
    end else begin
      hist    = {hist[30:0], sequence_in};
      nbits   = nbits + 1;
      exp_out = (nbits >= W) && (hist[W-1:0] == PAT);
      if (exp_out && exp_cnt < (1 << CW) - 1) exp_cnt = exp_cnt + 1;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    if (armed) begin
      chk("cycle_out", {31'd0, detector_out}, {31'd0, exp_out});
`ifdef SEQ_DET_COUNT_EN
      chk("cycle_count", 32'(detect_count), 32'(exp_cnt));
`endif
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset       = 1'b1;
      sequence_in = i[0];
      @(posedge clock);
      #1;
    end
  endtask

  // Feed n bits (bits[n-1] first); outs collects detector_out after each edge,
  // first bit's response in outs[n-1].
  task automatic run_seq(input logic [31:0] bits, input int n, output logic [31:0] outs);
    outs = '0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clock);
      reset       = 1'b0;
      sequence_in = bits[i];
      @(posedge clock);
      #1;
      outs = {outs[30:0], detector_out};
    end
  endtask

  logic [31:0] outs;

  initial begin
    // Reset hold with toggling input.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      reset       = 1'b1;
      sequence_in = i[0];
      @(posedge clock);
      #1;
      chk("reset_hold", {31'd0, detector_out}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
      chk("reset_count", 32'(detect_count), 32'd0);
`endif
    end
    run_seq(32'b000, 3, outs);
    chk("post_reset_idle", outs, 32'b000);

    // Basic match then a 0.
    do_reset(1);
    run_seq(32'b10110, 5, outs);
    chk("basic_match", outs, 32'b00010);
    chk("basic_model", {31'd0, exp_out}, 32'd0);

    // Overlapping matches.
    do_reset(1);
    run_seq(32'b1011011, 7, outs);
    chk("overlap", outs, 32'b0001001);
    chk("overlap_model", {31'd0, exp_out}, 32'd1);
`ifdef SEQ_DET_COUNT_EN
    chk("overlap_count", 32'(detect_count), 32'd2);
`endif

    // Fallback: 1111 and 1010 must not hit.
    do_reset(1);
    run_seq(32'b11110100001011, 14, outs);
    chk("fallback", outs, 32'b00000000000001);

    // Reset mid-pattern discards the partial match.
    do_reset(1);
    run_seq(32'b101, 3, outs);
    chk("mid_prefix", outs, 32'b000);
    do_reset(1);
    run_seq(32'b1, 1, outs);
    chk("mid_after_reset", outs, 32'b0);
    run_seq(32'b011, 3, outs);
    chk("mid_complete", outs, 32'b001);

`ifdef SEQ_DET_COUNT_EN
    // Five overlapping matches; 2-bit counter holds at 3.
    do_reset(1);
    run_seq(32'b1011011011011011, 16, outs);
    chk("sat_pulses", outs, 32'b0001001001001001);
    chk("sat_count", 32'(detect_count), 32'd3);
`endif

    // Random stream with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      reset       = ($urandom_range(0, 79) == 0);
      sequence_in = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
